node_resp_collector: RTL and testbench
======================================

# node_resp_collector

Upward response collector for a generated module-hierarchy node. The node fans out to NUM_CHILD child instances; this block is the return path. It gathers exactly one response word from each child per round and arbitrates round-robin. Accepted words go out on a single registered, tagged valid/ready stream, and the block signals completion of each round to the parent.

## Interface
Parameters:
- NUM_CHILD, 5, number of child channels (2..8)
- DATA_W, 8, response word width
- IDX_W, $clog2(NUM_CHILD), child tag width (3 for default)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset, synchronous, active-low
- c_valid  in  NUM_CHILD  per-child response valid
- c_data  in  NUM_CHILD*DATA_W  per-child word; child i at bits [i*DATA_W +: DATA_W]
- c_ready  out  NUM_CHILD  per-child accept, at most one bit high (one-hot or zero)
- m_valid  out  1  output word valid
- m_ready  in  1  parent accepts output word
- m_data  out  DATA_W  output word
- m_idx  out  IDX_W  index of the child that produced m_data
- round_done  out  1  one-cycle pulse: all NUM_CHILD children served this round
- round_cnt  out  8  completed-round counter, wraps 255->0

## Operation
- State: served mask (NUM_CHILD bits), rr pointer (IDX_W, range 0..NUM_CHILD-1), output register {m_valid, m_idx, m_data}, round_done flop, round_cnt.
- Eligible set = c_valid & ~served.
- load_en = !m_valid || m_ready.
- Grant: first eligible index scanning rr, rr+1, …, wrapping mod NUM_CHILD. c_ready = one-hot(grant) when load_en and the eligible set is non-empty, else 0. c_ready is combinational from c_valid, served, rr, m_valid and m_ready.
- Transfer on child g when c_valid[g] && c_ready[g]. On the next edge:
  - m_data <= child g word; m_idx <= g; m_valid <= 1
  - served[g] <= 1
  - rr <= (g+1) mod NUM_CHILD
- Output drained (m_valid && m_ready) with no new transfer: m_valid <= 0; m_data and m_idx hold.
- Round completion: if (served | onehot(g)) == all-ones on a transfer:
  - served <= 0 (not all-ones)
  - round_done <= 1 for exactly one cycle
  - round_cnt <= round_cnt+1
- A child already served in the current round is never granted, even if it holds c_valid. Its c_ready stays 0 until the round clears.
- Non-served children with c_valid low do not block the round; the round simply stays open.
- Children must hold c_valid and c_data stable until accepted; the block does not check this.
- Reset values: m_valid 0, m_data 0, m_idx 0, round_done 0, round_cnt 0, served 0, rr 0. c_ready is 0 while rst_n is low, independent of c_valid.
- Reset mid-round discards the served mask and any held output word. No round_done is generated.

## Timing
- Latency: child transfer at edge N -> m_valid high from edge N, i.e. data is visible the cycle after c_ready.
- Throughput: one word per cycle when m_ready stays high. Back-to-back transfers occur while the output is drained in the same cycle (load_en via m_ready).
- m_valid low and m_ready low: load allowed.
- m_valid high and m_ready low: no grant. m_valid, m_data and m_idx are held stable until accepted.
- round_done rises on the same edge that m_valid presents the round's final word.
- The first grant of a new round is possible in the cycle immediately after round_done rises.
- Simultaneous drain and load: the new word replaces the drained one; m_valid stays 1 with no bubble.
- round_cnt wrap: 255 + 1 = 0, with round_done still pulsed.

## Test plan
- Reset/idle:
  - Stimulus: hold rst_n=0 for 3 cycles with all c_valid=1.
  - Required: c_ready=0, m_valid=0, round_cnt=0 throughout.
  - After release: first grant goes to child 0.
- Full round, m_ready=1:
  - Stimulus: all five children valid, child i data = 0x10+i.
  - Required: outputs (idx,data) = (0,0x10),(1,0x11),(2,0x12),(3,0x13),(4,0x14) on 5 consecutive cycles.
  - round_done pulses with (4,0x14); round_cnt = 1.
- Served masking:
  - Stimulus: child 2 holds valid with data 0xAA across two rounds while the others deliver late.
  - Required: child 2 is granted once per round only, and c_ready[2]=0 after its grant until round_done.
- Backpressure:
  - Stimulus: m_ready=0 for 4 cycles while m_valid=1 with (1,0x55).
  - Required: outputs stable and c_ready=0 for those 4 cycles.
  - m_ready rise gives back-to-back delivery with no lost or duplicated word.
- Round-robin fairness:
  - Stimulus: rr=3 after a partial round; children 0 and 4 valid, the rest served.
  - Required: grant order 4 then 0; round_done follows the grant to 0.
- Counter wrap and mid-round reset:
  - Stimulus: run 256 rounds.
  - Required: round_cnt returns to 0 with a pulse on the 256th round.
  - Stimulus: assert rst_n=0 after 2 of 5 grants.
  - Required: served clears, the next round starts at child 0, and no round_done is produced.

Source files
------------

// File: rtl/node_resp_collector.sv
// rtl/node_resp_collector.sv - collects one response per child per round, round-robin, onto a registered tagged stream
module node_resp_collector #(
  parameter int NUM_CHILD = 5,
  parameter int DATA_W    = 8,
  parameter int IDX_W     = $clog2(NUM_CHILD)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CHILD-1:0]        c_valid,
  input  logic [NUM_CHILD*DATA_W-1:0] c_data,
  output logic [NUM_CHILD-1:0]        c_ready,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_W-1:0]           m_data,
  output logic [IDX_W-1:0]            m_idx,
  output logic                        round_done,
  output logic [7:0]                  round_cnt
);

  logic [NUM_CHILD-1:0] served;
  logic [IDX_W-1:0]     rr;
  logic [NUM_CHILD-1:0] eligible;
  logic                 load_en;
  logic                 found;
  logic                 xfer;
  logic                 last_word;
  logic [IDX_W-1:0]     grant;
  logic [IDX_W:0]       cand;
  logic [NUM_CHILD-1:0] grant_oh;

  assign eligible = c_valid & ~served;
  assign load_en  = !m_valid || m_ready;

  // Scan offsets from the far end back toward rr so the nearest eligible child wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int k = NUM_CHILD - 1; k >= 0; k--) begin
      cand = {1'b0, rr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_CHILD)) begin
        cand = cand - (IDX_W+1)'(NUM_CHILD);
      end
      if (eligible[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        grant = cand[IDX_W-1:0];
      end
    end
  end

  assign grant_oh  = found ? (NUM_CHILD'(1) << grant) : '0;
  assign c_ready   = (rst_n && load_en) ? grant_oh : '0;
  assign xfer      = |(c_valid & c_ready);
  assign last_word = &(served | grant_oh);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      served     <= '0;
      rr         <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_idx      <= '0;
      round_done <= 1'b0;
      round_cnt  <= '0;
    end else begin
      round_done <= 1'b0;
      if (xfer) begin
        m_valid <= 1'b1;
        m_data  <= c_data[grant*DATA_W +: DATA_W];
        m_idx   <= grant;
        rr      <= (grant == IDX_W'(NUM_CHILD - 1)) ? '0 : grant + 1'b1;
        if (last_word) begin
          served     <= '0;
          round_done <= 1'b1;
          round_cnt  <= round_cnt + 8'd1;
        end else begin
          served <= served | grant_oh;
        end
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_node_resp_collector.sv
// tb/tb_node_resp_collector.sv - randomized and directed bench for node_resp_collector against a round/served-set model
module tb_node_resp_collector;
  localparam int N  = 5;
  localparam int DW = 8;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  c_valid;
  logic [N*DW-1:0] c_data;
  logic [N-1:0]  c_ready;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_idx;
  logic          round_done;
  logic [7:0]    round_cnt;
  logic [DW-1:0] cdat [N];

  node_resp_collector #(.NUM_CHILD(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .c_valid(c_valid), .c_data(c_data), .c_ready(c_ready),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx),
    .round_done(round_done), .round_cnt(round_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    c_data = '0;
    for (int i = 0; i < N; i++) c_data[i*DW +: DW] = cdat[i];
  end

  // reference model state
  bit served [N];
  int rr;
  bit e_mv;
  int e_idx;
  int e_data;
  bit e_rd;
  int e_cnt;
  int last_g;
  int rounds_total;
  int n_checks;
  int n_pass;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // One clock: check DUT against model at negedge, advance model at posedge,
  // then the accepted child drops its valid.
  task automatic step();
    int g;
    int unsigned oh;
    bit all;
    @(negedge clk);
    g = -1;
    if (rst_n && (!e_mv || m_ready)) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (rr + k) % N;
        if (g < 0 && c_valid[j] && !served[j]) g = j;
      end
    end
    oh = (g >= 0) ? (32'd1 << g) : 32'd0;
    check_eq("c_ready", c_ready, oh);
    check_eq("m_valid", m_valid, e_mv);
    check_eq("m_idx", m_idx, e_idx);
    check_eq("m_data", m_data, e_data);
    check_eq("round_done", round_done, e_rd);
    check_eq("round_cnt", round_cnt, e_cnt);
    @(posedge clk);
    last_g = g;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) served[i] = 1'b0;
      rr = 0; e_mv = 0; e_idx = 0; e_data = 0; e_rd = 0; e_cnt = 0;
    end else begin
      e_rd = 0;
      if (g >= 0) begin
        e_mv = 1; e_idx = g; e_data = cdat[g];
        served[g] = 1'b1;
        rr = (g + 1) % N;
        all = 1'b1;
        for (int i = 0; i < N; i++) if (!served[i]) all = 1'b0;
        if (all) begin
          for (int i = 0; i < N; i++) served[i] = 1'b0;
          e_rd = 1;
          e_cnt = (e_cnt + 1) % 256;
          rounds_total++;
        end
      end else if (e_mv && m_ready) begin
        e_mv = 0;
      end
    end
    #1;
    if (g >= 0) c_valid[g] = 1'b0;
  endtask

  task automatic run_until_round(input int maxc);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < maxc) begin
      step();
      n++;
      got = e_rd;
    end
    check_eq("round_reached", got, 1);
  endtask

  initial begin
    int g2;
    int r0;
    int n;
    n_checks = 0; n_pass = 0; rounds_total = 0; last_g = -1;
    for (int i = 0; i < N; i++) served[i] = 1'b0;
    rr = 0; e_mv = 0; e_idx = 0; e_data = 0; e_rd = 0; e_cnt = 0;

    // reset with every child requesting
    rst_n = 1'b0; m_ready = 1'b1; c_valid = '1;
    for (int i = 0; i < N; i++) cdat[i] = DW'(8'h10 + i);
    @(posedge clk); #1;
    repeat (3) step();

    // full round with continuous drain
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      step();
      check_eq("full_idx", m_idx, i);
      check_eq("full_data", m_data, 8'h10 + i);
      check_eq("full_rd", round_done, (i == N - 1));
    end
    check_eq("full_cnt", round_cnt, 1);

    // served masking: child 2 keeps requesting across two rounds
    g2 = 0; r0 = rounds_total; n = 0;
    c_valid = 5'b00100; cdat[2] = 8'hAA;
    step();
    check_eq("mask_first", last_g, 2);
    if (last_g == 2) g2++;
    for (int i = 0; i < 3; i++) begin
      c_valid[2] = 1'b1;
      step();
      if (last_g == 2) g2++;
      check_eq("mask_cready2", c_ready[2], 0);
    end
    while (rounds_total - r0 < 2 && n < 100) begin
      c_valid[2] = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (i != 2 && !c_valid[i] && $urandom_range(99) < 40) begin
          c_valid[i] = 1'b1;
          cdat[i] = DW'($urandom_range(255));
        end
      end
      step();
      n++;
      if (last_g == 2) g2++;
    end
    check_eq("mask_rounds", rounds_total - r0, 2);
    check_eq("mask_grants2", g2, 2);

    // backpressure holding (1,0x55)
    c_valid = 5'b00010; cdat[1] = 8'h55; m_ready = 1'b1;
    step();
    check_eq("bp_grant", last_g, 1);
    m_ready = 1'b0;
    for (int i = 0; i < N; i++) if (i != 1) begin c_valid[i] = 1'b1; cdat[i] = DW'($urandom_range(255)); end
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("bp_mv", m_valid, 1);
      check_eq("bp_idx", m_idx, 1);
      check_eq("bp_data", m_data, 8'h55);
      check_eq("bp_cready", c_ready, 0);
    end
    m_ready = 1'b1;
    step();
    check_eq("bp_nobubble_mv", m_valid, 1);
    check_eq("bp_next_idx", m_idx, 2);
    run_until_round(20);

    // round-robin: serve 3,1,2 leaving rr=3, then 0 and 4 compete
    c_valid = 5'b01000; cdat[3] = 8'h33; step();
    c_valid = 5'b00010; cdat[1] = 8'h31; step();
    c_valid = 5'b00100; cdat[2] = 8'h32; step();
    c_valid = 5'b10001; cdat[0] = 8'h30; cdat[4] = 8'h34;
    step();
    check_eq("rr_first", last_g, 4);
    check_eq("rr_first_rd", round_done, 0);
    step();
    check_eq("rr_second", last_g, 0);
    check_eq("rr_round_done", round_done, 1);

    // random traffic until 256 rounds total have completed
    r0 = rounds_total; n = 0;
    while (rounds_total - r0 < 251 && n < 20000) begin
      for (int i = 0; i < N; i++) begin
        if (!c_valid[i] && $urandom_range(99) < 60) begin
          c_valid[i] = 1'b1;
          cdat[i] = DW'($urandom_range(255));
        end
      end
      m_ready = ($urandom_range(99) < 70);
      step();
      n++;
    end
    check_eq("wrap_rounds", rounds_total, 256);
    check_eq("wrap_cnt", round_cnt, 0);
    check_eq("wrap_pulse", round_done, 1);

    // reset after two grants of a round
    m_ready = 1'b1; c_valid = '1;
    for (int i = 0; i < N; i++) cdat[i] = DW'($urandom_range(255));
    step(); step();
    rst_n = 1'b0;
    step();
    check_eq("rst_rd", round_done, 0);
    check_eq("rst_mv", m_valid, 0);
    rst_n = 1'b1; c_valid = '1;
    step();
    check_eq("rst_first_grant", last_g, 0);
    check_eq("rst_no_rd", round_done, 0);
    run_until_round(20);
    check_eq("rst_cnt", round_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
